// File: rtl/ser_rx_link_sync.sv
`timescale 1ns/1ps
// Receive-link synchronisation controller: classifies each aligned word, runs the
// HUNT/ACQUIRE/SYNC/LOSS link FSM, requests re-alignment and forwards data words.
module ser_rx_link_sync #(
  parameter int ACQ_COMMAS     = 4,
  parameter int ERR_LIMIT      = 4,
  parameter int GOOD_RUN       = 16,
  parameter int COMMA_TIMEOUT  = 1024,
  parameter int REALIGN_CYCLES = 8
) (
  input  logic        ser_rx_clk_i,
  input  logic        ser_rx_rst_n,
  input  logic        link_en_i,
  input  logic        clr_i,
  input  logic [15:0] ser_r_i,
  input  logic        ser_rklsb_i,
  input  logic        ser_rkmsb_i,
  input  logic        ser_err_i,
  output logic        link_up_o,
  output logic        realign_o,
  output logic [1:0]  state_o,
  output logic [7:0]  loss_cnt_o,
  output logic [15:0] rx_data_o,
  output logic [1:0]  rx_k_o,
  output logic        rx_valid_o
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    SYNC    = 2'd2,
    LOSS    = 2'd3
  } state_t;

  localparam logic [4:0]  ACQ_TGT   = 5'(ACQ_COMMAS);
  localparam logic [4:0]  ERR_TGT   = 5'(ERR_LIMIT);
  localparam logic [7:0]  GOOD_LAST = 8'(GOOD_RUN - 1);
  localparam logic [16:0] TO_TGT    = 17'(COMMA_TIMEOUT);
  localparam logic [7:0]  RL_LAST   = 8'(REALIGN_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_acq_cnt, w_acq_nxt;
  logic [3:0]  r_err_cnt, w_err_nxt;
  logic [7:0]  r_good_cnt, w_good_nxt;
  logic [15:0] r_to_cnt, w_to_nxt;
  logic [7:0]  r_rl_cnt, w_rl_nxt;
  logic [7:0]  r_loss_cnt;
  logic [15:0] r_rx_data;
  logic [1:0]  r_rx_k;
  logic        r_rx_valid;

  logic        w_err_word, w_comma, w_data;
  logic        w_timeout, w_lost, w_loss_entry;
  logic [4:0]  w_acq_inc, w_err_inc;
  logic [16:0] w_to_inc;

  // A K-comma in the high byte means the aligner locked on the wrong byte.
  assign w_err_word = ser_err_i | (ser_rkmsb_i & (ser_r_i[15:8] == 8'h3C));
  assign w_comma    = ~w_err_word & ser_rklsb_i & (ser_r_i[7:0] == 8'h3C);
  assign w_data     = ~w_err_word & ~w_comma;

  assign w_acq_inc = {1'b0, r_acq_cnt} + 5'd1;
  assign w_err_inc = {1'b0, r_err_cnt} + 5'd1;
  assign w_to_inc  = {1'b0, r_to_cnt} + 17'd1;
  assign w_timeout = ~w_comma & (w_to_inc == TO_TGT);

  always_ff @(posedge ser_rx_clk_i or negedge ser_rx_rst_n) begin
    if (!ser_rx_rst_n) r_state <= HUNT;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acq_nxt    = r_acq_cnt;
    w_err_nxt    = r_err_cnt;
    w_good_nxt   = r_good_cnt;
    w_to_nxt     = r_to_cnt;
    w_rl_nxt     = r_rl_cnt;
    w_lost       = 1'b0;
    w_loss_entry = 1'b0;

    case (r_state)
      HUNT: begin
        w_acq_nxt  = '0;
        w_err_nxt  = '0;
        w_good_nxt = '0;
        w_to_nxt   = '0;
        w_rl_nxt   = '0;
        if (w_comma) begin
          w_state_nxt = ACQUIRE;
          w_acq_nxt   = 4'd1;
        end
      end

      ACQUIRE: begin
        if (w_err_word || w_timeout) begin
          w_state_nxt = HUNT;
          w_acq_nxt   = '0;
          w_to_nxt    = '0;
        end else if (w_comma) begin
          w_acq_nxt = w_acq_inc[3:0];
          w_to_nxt  = '0;
          if (w_acq_inc == ACQ_TGT) begin
            w_state_nxt = SYNC;
            w_err_nxt   = '0;
            w_good_nxt  = '0;
          end
        end else begin
          w_to_nxt = w_to_inc[15:0];
        end
      end

      SYNC: begin
        w_to_nxt = w_comma ? 16'd0 : w_to_inc[15:0];
        w_lost   = w_timeout;
        if (w_err_word) begin
          w_err_nxt  = w_err_inc[3:0];
          w_good_nxt = '0;
          if (w_err_inc == ERR_TGT) w_lost = 1'b1;
        end else if (r_good_cnt == GOOD_LAST) begin
          // A full good run pays back one error; with none owed the run just saturates.
          if (r_err_cnt != 4'd0) begin
            w_err_nxt  = r_err_cnt - 4'd1;
            w_good_nxt = '0;
          end
        end else begin
          w_good_nxt = r_good_cnt + 8'd1;
        end
        if (w_lost) begin
          w_state_nxt  = LOSS;
          w_loss_entry = 1'b1;
          w_acq_nxt    = '0;
          w_err_nxt    = '0;
          w_good_nxt   = '0;
          w_to_nxt     = '0;
          w_rl_nxt     = '0;
        end
      end

      LOSS: begin
        if (r_rl_cnt == RL_LAST) begin
          w_state_nxt = HUNT;
          w_rl_nxt    = '0;
        end else begin
          w_rl_nxt = r_rl_cnt + 8'd1;
        end
      end

      default: w_state_nxt = HUNT;
    endcase

    if (!link_en_i) begin
      w_state_nxt  = HUNT;
      w_loss_entry = 1'b0;
      w_acq_nxt    = '0;
      w_err_nxt    = '0;
      w_good_nxt   = '0;
      w_to_nxt     = '0;
      w_rl_nxt     = '0;
    end
  end

  always_ff @(posedge ser_rx_clk_i or negedge ser_rx_rst_n) begin
    if (!ser_rx_rst_n) begin
      r_acq_cnt  <= '0;
      r_err_cnt  <= '0;
      r_good_cnt <= '0;
      r_to_cnt   <= '0;
      r_rl_cnt   <= '0;
    end else begin
      r_acq_cnt  <= w_acq_nxt;
      r_err_cnt  <= w_err_nxt;
      r_good_cnt <= w_good_nxt;
      r_to_cnt   <= w_to_nxt;
      r_rl_cnt   <= w_rl_nxt;
    end
  end

  // Clear takes priority over a loss counted in the same cycle.
  always_ff @(posedge ser_rx_clk_i or negedge ser_rx_rst_n) begin
    if (!ser_rx_rst_n)                                r_loss_cnt <= '0;
    else if (clr_i)                                   r_loss_cnt <= '0;
    else if (w_loss_entry && r_loss_cnt != 8'hFF)     r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  always_ff @(posedge ser_rx_clk_i or negedge ser_rx_rst_n) begin
    if (!ser_rx_rst_n) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_k     <= '0;
    end else begin
      r_rx_valid <= (r_state == SYNC) && w_data;
      if ((r_state == SYNC) && w_data) begin
        r_rx_data <= ser_r_i;
        r_rx_k    <= {ser_rkmsb_i, ser_rklsb_i};
      end
    end
  end

  assign state_o    = r_state;
  assign link_up_o  = (r_state == SYNC);
  assign realign_o  = (r_state == LOSS);
  assign loss_cnt_o = r_loss_cnt;
  assign rx_data_o  = r_rx_data;
  assign rx_k_o     = r_rx_k;
  assign rx_valid_o = r_rx_valid;

endmodule

// File: tb/tb_ser_rx_link_sync.sv
`timescale 1ns/1ps
// Bench for ser_rx_link_sync: a vector table, directed multi-cycle sequences and
// random traffic, all checked every cycle against a rule-level reference model.
module tb_ser_rx_link_sync;

  localparam int ACQ  = 4;
  localparam int ERRL = 4;
  localparam int GR   = 16;
  localparam int TO   = 1024;
  localparam int RC   = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        linkEn;
  logic        clr;
  logic [15:0] rWord;
  logic        kLsb, kMsb, decErr;
  logic        linkUp, realign, rxValid;
  logic [1:0]  stateO, rxK;
  logic [7:0]  lossCnt;
  logic [15:0] rxData;

  int checkCount = 0;
  int passCount  = 0;

  int          mState, mAcq, mErr, mGood, mTo, mRl, mLoss;
  logic        mValid;
  logic [15:0] mData;
  logic [1:0]  mK;

  typedef struct {
    logic [15:0] word;
    logic        kl, km, er, en;
    logic [1:0]  expState;
    logic        expValid;
    logic [15:0] expData;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  ser_rx_link_sync #(
    .ACQ_COMMAS(ACQ), .ERR_LIMIT(ERRL), .GOOD_RUN(GR),
    .COMMA_TIMEOUT(TO), .REALIGN_CYCLES(RC)
  ) dut (
    .ser_rx_clk_i(clk),
    .ser_rx_rst_n(rstN),
    .link_en_i(linkEn),
    .clr_i(clr),
    .ser_r_i(rWord),
    .ser_rklsb_i(kLsb),
    .ser_rkmsb_i(kMsb),
    .ser_err_i(decErr),
    .link_up_o(linkUp),
    .realign_o(realign),
    .state_o(stateO),
    .loss_cnt_o(lossCnt),
    .rx_data_o(rxData),
    .rx_k_o(rxK),
    .rx_valid_o(rxValid)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mkVec(input logic [15:0] w, input logic kl, input logic km,
                                 input logic er, input logic en, input logic [1:0] st,
                                 input logic v, input logic [15:0] d);
    vec_t t;
    t.word = w; t.kl = kl; t.km = km; t.er = er; t.en = en;
    t.expState = st; t.expValid = v; t.expData = d;
    return t;
  endfunction

  task automatic modelClear();
    mState = 0; mAcq = 0; mErr = 0; mGood = 0; mTo = 0; mRl = 0;
  endtask

  task automatic modelReset();
    modelClear();
    mLoss = 0; mValid = 1'b0; mData = '0; mK = '0;
  endtask

  // Reference model: one word in, link rules applied in plain integer arithmetic.
  task automatic modelStep(input logic [15:0] w, input logic kl, input logic km,
                           input logic er, input logic en, input logic cl);
    bit isErr, isComma, lost, entered;
    isErr   = er || (km && w[15:8] == 8'h3C);
    isComma = !isErr && kl && w[7:0] == 8'h3C;
    lost    = 0;
    entered = 0;
    mValid = (mState == 2) && !isErr && !isComma;
    if (mValid) begin
      mData = w;
      mK    = {km, kl};
    end
    if (!en) modelClear();
    else begin
      case (mState)
        0: if (isComma) begin mState = 1; mAcq = 1; mTo = 0; end
        1: begin
          if (isErr) modelClear();
          else if (isComma) begin
            mAcq++; mTo = 0;
            if (mAcq == ACQ) begin mState = 2; mErr = 0; mGood = 0; end
          end else begin
            mTo++;
            if (mTo == TO) modelClear();
          end
        end
        2: begin
          if (isComma) mTo = 0;
          else begin mTo++; if (mTo == TO) lost = 1; end
          if (isErr) begin
            mGood = 0; mErr++;
            if (mErr == ERRL) lost = 1;
          end else begin
            mGood++;
            if (mGood == GR) begin
              if (mErr > 0) begin mErr--; mGood = 0; end
              else mGood = GR - 1;
            end
          end
          if (lost) begin modelClear(); mState = 3; entered = 1; end
        end
        default: begin
          mRl++;
          if (mRl == RC) modelClear();
        end
      endcase
    end
    if (cl) mLoss = 0;
    else if (entered && mLoss < 255) mLoss++;
  endtask

  function automatic logic [31:0] dutVec();
    return {1'b0, stateO, linkUp, realign, lossCnt, rxValid, rxK, rxData};
  endfunction

  function automatic logic [31:0] modelVec();
    return {1'b0, 2'(mState), (mState == 2), (mState == 3), 8'(mLoss), mValid, mK, mData};
  endfunction

  task automatic applyStimulus(input logic [15:0] w, input logic kl, input logic km,
                               input logic er, input logic en, input logic cl,
                               input string name);
    rWord = w; kLsb = kl; kMsb = km; decErr = er; linkEn = en; clr = cl;
    @(posedge clk);
    #1;
    modelStep(w, kl, km, er, en, cl);
    checkOutput(name, dutVec(), modelVec());
  endtask

  task automatic commaW(input string n);  applyStimulus(16'h003C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, n); endtask
  task automatic dataW(input string n);   applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n); endtask
  task automatic errW(input string n);    applyStimulus(16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, n); endtask
  task automatic goHunt();                applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "en_off"); endtask

  task automatic syncUp(input string n);
    goHunt();
    repeat (ACQ) begin
      dataW(n); dataW(n); dataW(n);
      commaW(n);
    end
    checkOutput({n, "_link_up"}, 32'(linkUp), 32'd1);
  endtask

  task automatic runLoss(input string n);
    repeat (RC) dataW(n);
  endtask

  initial begin
    int n, lc;
    logic [15:0] w;
    logic kl, km, er, en, cl;
    int r;

    rstN = 1'b0; linkEn = 1'b1; clr = 1'b0;
    rWord = '0; kLsb = 1'b0; kMsb = 1'b0; decErr = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", dutVec(), 32'd0);
    rstN = 1'b1;

    // Acquisition table: comma every 4th word, then data/comma/error mix in SYNC.
    tbl.push_back(mkVec(16'h003C, 1, 0, 0, 1, 2'd1, 0, 16'h0000));
    for (int i = 0; i < 3; i++) begin
      repeat (3) tbl.push_back(mkVec(16'h1234, 0, 0, 0, 1, 2'd1, 0, 16'h0000));
      tbl.push_back(mkVec(16'h003C, 1, 0, 0, 1, (i == 2) ? 2'd2 : 2'd1, 0, 16'h0000));
    end
    tbl.push_back(mkVec(16'h1234, 0, 0, 0, 1, 2'd2, 1, 16'h1234));
    tbl.push_back(mkVec(16'h003C, 1, 0, 0, 1, 2'd2, 0, 16'h1234));
    tbl.push_back(mkVec(16'h3C00, 0, 1, 0, 1, 2'd2, 0, 16'h1234));
    tbl.push_back(mkVec(16'h5678, 0, 0, 0, 1, 2'd2, 1, 16'h5678));
    tbl.push_back(mkVec(16'h9ABC, 0, 0, 1, 1, 2'd2, 0, 16'h5678));
    tbl.push_back(mkVec(16'h00BC, 1, 0, 0, 1, 2'd2, 1, 16'h00BC));
    tbl.push_back(mkVec(16'h3C3C, 1, 1, 0, 1, 2'd2, 0, 16'h00BC));
    tbl.push_back(mkVec(16'h003C, 1, 0, 0, 0, 2'd0, 0, 16'h00BC));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].word, tbl[i].kl, tbl[i].km, tbl[i].er, tbl[i].en, 1'b0,
                    $sformatf("tbl%0d_model", i));
      checkOutput($sformatf("tbl%0d_state", i), 32'(stateO), 32'(tbl[i].expState));
      checkOutput($sformatf("tbl%0d_valid", i), 32'(rxValid), 32'(tbl[i].expValid));
      checkOutput($sformatf("tbl%0d_data", i), 32'(rxData), 32'(tbl[i].expData));
    end

    // Four spaced errors force LOSS; realign must last exactly RC cycles.
    syncUp("errloss");
    for (int i = 0; i < ERRL; i++) begin
      errW("errloss_err");
      if (i < ERRL - 1) begin dataW("errloss_good"); dataW("errloss_good"); commaW("errloss_good"); end
    end
    checkOutput("errloss_state", 32'(stateO), 32'd3);
    n = 0;
    while (realign && n < 20) begin
      commaW("errloss_ignored");
      n++;
    end
    checkOutput("realign_len", 32'(n), 32'(RC));
    checkOutput("errloss_hunt", 32'(stateO), 32'd0);
    checkOutput("errloss_losscnt", 32'(lossCnt), 32'd1);

    // Error decay: 3 errors, 48 good words, 3 more errors stays in SYNC.
    syncUp("decay");
    repeat (3) errW("decay_err");
    for (int i = 0; i < 48; i++) begin
      if (i % 4 == 3) commaW("decay_good");
      else dataW("decay_good");
    end
    repeat (3) errW("decay_err2");
    checkOutput("decay_link_up", 32'(linkUp), 32'd1);
    checkOutput("decay_losscnt", 32'(lossCnt), 32'd1);

    // Comma starvation in SYNC.
    syncUp("tosync");
    n = 0;
    do begin dataW("tosync_data"); n++; end while (linkUp && n < 1100);
    checkOutput("tosync_words", 32'(n), 32'(TO));
    checkOutput("tosync_losscnt", 32'(lossCnt), 32'd2);
    runLoss("tosync_loss");
    checkOutput("tosync_hunt", 32'(stateO), 32'd0);

    // Comma starvation in ACQUIRE returns to HUNT without counting a loss.
    goHunt();
    commaW("toacq_comma");
    lc = mLoss;
    n = 0;
    do begin dataW("toacq_data"); n++; end while (stateO == 2'd1 && n < 1100);
    checkOutput("toacq_words", 32'(n), 32'(TO));
    checkOutput("toacq_state", 32'(stateO), 32'd0);
    checkOutput("toacq_losscnt", 32'(lossCnt), 32'(lc));

    // High-byte comma during ACQUIRE is misalignment.
    goHunt();
    commaW("hibyte_c1");
    commaW("hibyte_c2");
    applyStimulus(16'h3C00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "hibyte_err");
    checkOutput("hibyte_hunt", 32'(stateO), 32'd0);

    // Disable mid-LOSS.
    syncUp("abort");
    repeat (ERRL) errW("abort_err");
    dataW("abort_loss"); dataW("abort_loss");
    applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_en_off");
    checkOutput("abort_realign", 32'(realign), 32'd0);
    checkOutput("abort_state", 32'(stateO), 32'd0);
    checkOutput("abort_losscnt", 32'(lossCnt), 32'd3);

    // Asynchronous reset mid-LOSS.
    syncUp("arst");
    repeat (ERRL) errW("arst_err");
    dataW("arst_loss");
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst_realign", 32'(realign), 32'd0);
    checkOutput("arst_outputs", dutVec(), 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    modelReset();

    // Saturation of the loss counter.
    for (int k = 0; k < 256; k++) begin
      syncUp("sat");
      repeat (ERRL) errW("sat_err");
      runLoss("sat_loss");
    end
    checkOutput("sat_losscnt", 32'(lossCnt), 32'd255);

    // Clear on the same cycle as a loss entry.
    syncUp("clrent");
    repeat (ERRL - 1) errW("clrent_err");
    applyStimulus(16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "clrent_entry");
    checkOutput("clrent_state", 32'(stateO), 32'd3);
    checkOutput("clrent_losscnt", 32'(lossCnt), 32'd0);
    runLoss("clrent_loss");

    // Random traffic against the model.
    goHunt();
    for (int i = 0; i < 4000; i++) begin
      r  = $urandom_range(0, 99);
      w  = 16'($urandom);
      kl = 1'($urandom_range(0, 1));
      km = 1'b0;
      er = 1'b0;
      if (r < 25) begin
        w[7:0] = 8'h3C;
        kl = 1'b1;
        km = 1'($urandom_range(0, 1));
      end else if (r < 30) begin
        er = 1'b1;
      end else if (r < 34) begin
        w[15:8] = 8'h3C;
        km = 1'b1;
      end
      en = ($urandom_range(0, 199) != 0);
      cl = ($urandom_range(0, 299) == 0);
      applyStimulus(w, kl, km, er, en, cl, "random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ser_rx_link_sync.md
# ser_rx_link_sync

Receive-link synchronisation controller for the USRP2 SERDES path. It sits directly after the receive byte aligner and classifies every aligned 16-bit word as comma, data or error. It runs the HUNT/ACQUIRE/SYNC/LOSS state machine that declares the link up or down, and requests an aligner re-alignment on loss of sync. While the link is up it forwards registered data words with a valid strobe.

## Interface
- ACQ_COMMAS, 4: comma words needed in HUNT/ACQUIRE to declare sync (legal range ≥2, ≤15)
- ERR_LIMIT, 4: error count in SYNC that forces LOSS (legal range ≥1, ≤15)
- GOOD_RUN, 16: consecutive good words in SYNC that remove one error count (≥1, ≤255)
- COMMA_TIMEOUT, 1024: words without a comma before LOSS, in ACQUIRE/SYNC (≥2, ≤65535)
- REALIGN_CYCLES, 8: cycles realign_o is held in LOSS (≥1, ≤255)
- ser_rx_clk_i  in  1  receive clock; all logic on posedge
- ser_rx_rst_n  in  1  asynchronous active-low reset
- link_en_i  in  1  link enable; low forces HUNT
- clr_i  in  1  synchronous clear of loss_cnt_o
- ser_r_i  in  16  aligned word from byte aligner, valid every cycle
- ser_rklsb_i  in  1  K flag, low byte
- ser_rkmsb_i  in  1  K flag, high byte
- ser_err_i  in  1  decoder code/disparity error for this word
- link_up_o  out  1  high while state is SYNC
- realign_o  out  1  high during LOSS; request to reset the byte aligner
- state_o  out  2  HUNT=0, ACQUIRE=1, SYNC=2, LOSS=3
- loss_cnt_o  out  8  saturating count of SYNC→LOSS transitions
- rx_data_o  out  16  registered data word
- rx_k_o  out  2  registered {rkmsb, rklsb}
- rx_valid_o  out  1  rx_data_o/rx_k_o hold a forwarded data word

## Operation
- Word classes are evaluated combinationally on the inputs each cycle:
  - error = ser_err_i, or (ser_rkmsb_i && ser_r_i[15:8]==8'h3C). A comma in the high byte is misalignment.
  - comma = !error && ser_rklsb_i && ser_r_i[7:0]==8'h3C.
  - data = neither error nor comma.
- Internal counters:
  - acq_cnt[3:0]
  - err_cnt[3:0]
  - good_cnt[7:0]
  - to_cnt[15:0]: words since the last comma
  - rl_cnt[7:0]
- HUNT:
  - All counters are 0.
  - comma → ACQUIRE, acq_cnt=1, to_cnt=0.
  - data/error → stay.
- ACQUIRE:
  - comma → acq_cnt+1 and to_cnt=0. If acq_cnt+1==ACQ_COMMAS → SYNC, with err_cnt=good_cnt=0.
  - data → to_cnt+1.
  - error → HUNT, all counters cleared.
  - to_cnt reaching COMMA_TIMEOUT → HUNT.
- SYNC:
  - error → err_cnt+1 and good_cnt=0. If err_cnt+1==ERR_LIMIT → LOSS.
  - comma or data → good_cnt+1. If good_cnt+1==GOOD_RUN and err_cnt>0 → err_cnt-1 and good_cnt=0. With err_cnt==0, good_cnt saturates at GOOD_RUN-1.
  - comma resets to_cnt; other words increment it. to_cnt reaching COMMA_TIMEOUT → LOSS.
  - If an error and the timeout occur in the same cycle → LOSS, counted once.
- LOSS:
  - On entry: loss_cnt_o+1 (saturates at 255) and rl_cnt=0.
  - realign_o=1 each cycle; inputs are ignored.
  - After REALIGN_CYCLES cycles in LOSS → HUNT, all counters cleared.
- link_en_i=0: next state is HUNT from any state, counters cleared, realign_o deasserts the next cycle. This aborts an in-progress LOSS; the loss already counted stays counted.
- clr_i: loss_cnt_o=0 next cycle. If a LOSS entry happens in the same cycle, clr_i wins and the result is 0.
- Data forwarding:
  - rx_valid_o is set next cycle iff state==SYNC and the word is data, with state evaluated before the transition in that cycle.
  - rx_data_o/rx_k_o are updated only when rx_valid_o is being set; otherwise they hold.
  - Commas and error words are never forwarded.

## Timing
- Reset (asynchronous, ser_rx_rst_n=0):
  - state HUNT, all counters 0.
  - link_up_o=0, realign_o=0, state_o=0, loss_cnt_o=0.
  - rx_data_o=0, rx_k_o=0, rx_valid_o=0.
  - Reset mid-LOSS drops realign_o immediately.
- All outputs are registered; state_o, link_up_o and realign_o decode the state register.
- link_up_o rises 1 cycle after the cycle sampling the ACQ_COMMAS-th comma.
- link_up_o falls 1 cycle after the error word reaching ERR_LIMIT, or after the timeout word.
- The same-cycle data word is not forwarded on the SYNC→LOSS edge once the state has left SYNC; forwarding is based on the current state.
- realign_o is high for exactly REALIGN_CYCLES consecutive cycles per loss, followed by HUNT.
- Data latency: input word to rx_data_o/rx_valid_o is 1 cycle. Throughput is one word per cycle.

## Test plan
- Reset, link_en_i=1, feed 16'h003C with rklsb=1 every 4th word and 16'h1234 otherwise → state_o steps 0→1→2. link_up_o rises 1 cycle after the 4th comma. rx_valid_o pulses with rx_data_o=16'h1234 only on data words.
- In SYNC, inject ser_err_i on 4 words separated by ≤15 good words → LOSS on the 4th. realign_o is high for exactly 8 cycles, loss_cnt_o=1, then state_o=0.
- In SYNC, inject 3 errors, then 48 good words, then 3 errors → err_cnt decays to 0, no LOSS, link_up_o stays 1.
- In SYNC, stop sending commas (data only) → LOSS after exactly 1024 words without a comma. In ACQUIRE, the same stimulus → HUNT with loss_cnt_o unchanged.
- Feed a high-byte comma (rkmsb=1, ser_r_i=16'h3C00) in ACQUIRE → HUNT. Assert link_en_i=0 mid-LOSS → realign_o=0 and state_o=0 next cycle.
- Force 256 losses → loss_cnt_o saturates at 255. Assert clr_i on a LOSS-entry cycle → loss_cnt_o=0.
